// File: rtl/mult_sequencer_pkg.sv
// Shared widths, constants and FSM state encoding for the signed shift-add multiplier.
package mult_sequencer_pkg;

    localparam int DW   = 8;
    localparam int DW_2 = 2 * DW;
    // Iteration counter must hold 0..DW-1 with headroom for the final increment.
    localparam int CW   = $clog2(DW + 1);

    localparam logic [DW_2-1:0] ZERO = '0;
    localparam logic [DW_2-1:0] ONE  = DW_2'(1);
    localparam logic [DW_2-1:0] TWO  = DW_2'(2);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        DONE
    } mult_state_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Multiplier datapath: operand capture, magnitudes, DW-step shift-add accumulate, sign fix.
// One action per strobe per cycle; result/sign registers change only on fix_i.
module mult_shift_add_dp
    import mult_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            capture_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            fix_i,
    input  logic [DW-1:0]   op_a_i,
    input  logic [DW-1:0]   op_b_i,
    output logic            last_iter_o,
    output logic            sign_o,
    output logic [DW_2-1:0] result_o
);

    localparam logic [DW-1:0] ZERO_OP = '0;

    logic [DW-1:0]   op_a_q,   op_a_d;
    logic [DW-1:0]   op_b_q,   op_b_d;
    logic [DW-1:0]   mag_a_q,  mag_a_d;
    logic [DW-1:0]   mag_b_q,  mag_b_d;
    logic [DW_2-1:0] acc_q,    acc_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            sign_q,   sign_d;
    logic            res_sign_q, res_sign_d;
    logic [DW_2-1:0] result_q, result_d;

    always_comb begin
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        acc_d      = acc_q;
        count_d    = count_q;
        sign_d     = sign_q;
        res_sign_d = res_sign_q;
        result_d   = result_q;

        if (capture_i) begin
            op_a_d = op_a_i;
            op_b_d = op_b_i;
        end

        // Most-negative operand negates to 2^(DW-1), which is exact as an unsigned magnitude.
        if (load_i) begin
            mag_a_d = op_a_q[DW-1] ? (ZERO_OP - op_a_q) : op_a_q;
            mag_b_d = op_b_q[DW-1] ? (ZERO_OP - op_b_q) : op_b_q;
            sign_d  = op_a_q[DW-1] ^ op_b_q[DW-1];
            acc_d   = ZERO;
            count_d = '0;
        end

        if (step_i) begin
            if (mag_b_q[0]) begin
                acc_d = acc_q + (DW_2'(mag_a_q) << count_q);
            end
            mag_b_d = mag_b_q >> 1;
            count_d = count_q + CW'(1);
        end

        if (fix_i) begin
            result_d   = sign_q ? (ZERO - acc_q) : acc_q;
            res_sign_d = sign_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            sign_q     <= 1'b0;
            res_sign_q <= 1'b0;
            result_q   <= '0;
        end else begin
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            sign_q     <= sign_d;
            res_sign_q <= res_sign_d;
            result_q   <= result_d;
        end
    end

    assign last_iter_o = (count_q == CW'(DW - 1));
    assign sign_o      = res_sign_q;
    assign result_o    = result_q;

endmodule

// File: rtl/mult_sequencer.sv
// Signed sequential multiplier controller: start/ready handshake, IDLE->LOAD->RUN->FIX->DONE.
// Done pulses DW+3 edges after acceptance; start outside IDLE is dropped, never queued.
module mult_sequencer
    import mult_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   multiplier,
    input  logic [DW-1:0]   multiplicand,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            sign,
    output logic [DW_2-1:0] result
);

    mult_state_t state_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;
    logic        last_iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // The pulse is registered off the DONE state, so it overlaps the following IDLE cycle.
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: state_q <= RUN;
                RUN: begin
                    if (last_iter) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    mult_shift_add_dp u_dp (
        .clk         (clk),
        .rst         (rst),
        .capture_i   ((state_q == IDLE) && start),
        .load_i      (state_q == LOAD),
        .step_i      (state_q == RUN),
        .fix_i       (state_q == FIX),
        .op_a_i      (multiplier),
        .op_b_i      (multiplicand),
        .last_iter_o (last_iter),
        .sign_o      (sign),
        .result_o    (result)
    );

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: latency, signed products, ignored starts, reset abort, back-to-back.
module tb_mult_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplier;
    logic [7:0]  multiplicand;
    logic        ready;
    logic        busy;
    logic        done;
    logic        sign;
    logic [15:0] result;

    int checks   = 0;
    int failures = 0;

    mult_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .sign         (sign),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Single start pulse, then count edges until done is seen (bounded).
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        multiplier   = a;
        multiplicand = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplier   = 8'h5A;
        multiplicand = 8'hA5;
        check("acc_ready_low", {31'd0, ready}, 32'd0);
        check("acc_busy_high", {31'd0, busy}, 32'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
    endtask

    initial begin
        int          lat;
        int          pulses;
        int          expv;
        logic [15:0] res_seen;
        logic        sign_seen;
        logic [7:0]  pa [3];
        logic [7:0]  pb [3];

        rst          = 1'b1;
        start        = 1'b0;
        multiplier   = '0;
        multiplicand = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",  {31'd0, ready}, 32'd1);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_sign",   {31'd0, sign},  32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 7 * 6
        do_op(8'd7, 8'd6, lat);
        check("t1_lat",    lat, 32'd11);
        check("t1_result", {16'd0, result}, 32'd42);
        check("t1_sign",   {31'd0, sign}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_done_clr", {31'd0, done},  32'd0);
        check("t1_ready",    {31'd0, ready}, 32'd1);
        check("t1_hold",     {16'd0, result}, 32'd42);

        // -5 * 3
        do_op(8'hFB, 8'd3, lat);
        check("t2_lat",    lat, 32'd11);
        check("t2_result", {16'd0, result}, 32'h0000FFF1);
        check("t2_sign",   {31'd0, sign}, 32'd1);

        // -128 * -128 and -128 * 127
        do_op(8'h80, 8'h80, lat);
        check("t3a_result", {16'd0, result}, 32'h00004000);
        check("t3a_sign",   {31'd0, sign}, 32'd0);
        do_op(8'h80, 8'h7F, lat);
        check("t3b_result", {16'd0, result}, 32'h0000C080);
        check("t3b_sign",   {31'd0, sign}, 32'd1);

        // Reset mid-RUN aborts without a done pulse
        @(negedge clk);
        multiplier   = 8'd7;
        multiplicand = 8'd6;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ready",  {31'd0, ready}, 32'd1);
        check("t5_busy",   {31'd0, busy},  32'd0);
        check("t5_result", {16'd0, result}, 32'd0);
        check("t5_done",   {31'd0, done},  32'd0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("t5_no_done", pulses, 32'd0);

        // 0 * -9 with a stray start during RUN
        @(negedge clk);
        multiplier   = 8'd0;
        multiplicand = 8'hF7;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        multiplier   = 8'd3;
        multiplicand = 8'd3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        pulses    = 0;
        res_seen  = 16'hDEAD;
        sign_seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                res_seen  = result;
                sign_seen = sign;
            end
        end
        check("t4_pulses", pulses, 32'd1);
        check("t4_result", {16'd0, res_seen}, 32'd0);
        check("t4_sign",   {31'd0, sign_seen}, 32'd1);

        // start held high across three operations
        for (int i = 0; i < 3; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
        @(negedge clk);
        multiplier   = pa[0];
        multiplicand = pb[0];
        start        = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                multiplier   = pa[i+1];
                multiplicand = pb[i+1];
            end else begin
                start = 1'b0;
            end
            lat = 0;
            while (lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
                if (done) break;
            end
            expv = int'($signed(pa[i])) * int'($signed(pb[i]));
            check("t6_lat",    lat, 32'd11);
            check("t6_result", {16'd0, result}, {16'd0, expv[15:0]});
            check("t6_sign",   {31'd0, sign}, {31'd0, pa[i][7] ^ pb[i][7]});
            if (i < 2) begin
                @(posedge clk);
                #1;
                check("t6_reaccept", {31'd0, busy}, 32'd1);
                check("t6_done_clr", {31'd0, done}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
